// File: rtl/s247_pkg.sv
// Shared types and constants for the S247 fence monitor: event codes,
// monitor FSM states and the default event-entry width.
package s247_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int TS_WIDTH_DEF   = 16;
    localparam int EVT_W          = 2 + TS_WIDTH_DEF + DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        EVT_EXIT      = 2'b00,
        EVT_ENTER_OUT = 2'b01,
        EVT_ALARM     = 2'b10,
        EVT_CLEAR     = 2'b11
    } evt_type_t;

    typedef enum logic [1:0] {
        MON_ARMED   = 2'b00,
        MON_SUSPECT = 2'b01,
        MON_ALARM   = 2'b10
    } mon_state_t;

    // Saturating 8-bit increment shared by the streak and drop counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/s247_evt_fifo.sv
// Synchronous event FIFO with extra-MSB pointers for full/empty distinction.
// A push while full is accepted only when a pop happens in the same cycle.
module s247_evt_fifo #(
    parameter int W     = 50,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         wr_en_s;
    logic         rd_en_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en_s = pop_i && !empty_o;
    assign wr_en_s = push_i && (!full_o || rd_en_s);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update; contents are cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/s247_fence_monitor.sv
// Fence monitor: classifies GEOCHECK samples, debounces outside runs into a
// sticky alarm and logs classification edges with timestamps into a FIFO.
module s247_fence_monitor
    import s247_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    TRIP_COUNT  = 3,
    parameter int                    FIFO_DEPTH  = 8,
    parameter int                    TS_WIDTH    = 16,
    parameter logic [DATA_WIDTH-1:0] INSIDE_CODE = 32'h0001_0000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             core_done,
    input  logic [DATA_WIDTH-1:0]            core_result,
    input  logic                             core_halt,
    input  logic                             clear_alarm,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [2+TS_WIDTH+DATA_WIDTH-1:0] evt_data,
    output logic                             alarm,
    output logic [7:0]                       streak,
    output logic                             overflow,
    output logic [7:0]                       drop_cnt
);

    localparam int         EW     = 2 + TS_WIDTH + DATA_WIDTH;
    localparam logic [7:0] TRIP_W = TRIP_COUNT[7:0];

    mon_state_t            state_q, state_d;
    logic [7:0]            streak_q, streak_d;
    logic                  alarm_q, alarm_d;
    logic [TS_WIDTH-1:0]   ts_q;
    logic                  overflow_q;
    logic [7:0]            drop_cnt_q;

    logic                  outside_s;
    logic [7:0]            streak_inc_s;
    logic                  push_s;
    evt_type_t             ptype_s;
    logic [DATA_WIDTH-1:0] presult_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  drop_s;

    assign outside_s    = core_halt || (core_result != INSIDE_CODE);
    assign streak_inc_s = sat_inc8(streak_q);

    // Classification, debounce FSM and event selection for the current sample.
    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        alarm_d   = alarm_q;
        push_s    = 1'b0;
        ptype_s   = EVT_EXIT;
        presult_s = core_result;
        if (clear_alarm && (state_q == MON_ALARM)) begin
            state_d   = MON_ARMED;
            streak_d  = 8'd0;
            alarm_d   = 1'b0;
            push_s    = 1'b1;
            ptype_s   = EVT_CLEAR;
            presult_s = '0;
        end else if (core_done) begin
            case (state_q)
                MON_ARMED: begin
                    if (outside_s) begin
                        streak_d = 8'd1;
                        push_s   = 1'b1;
                        if (TRIP_W == 8'd1) begin
                            state_d = MON_ALARM;
                            alarm_d = 1'b1;
                            ptype_s = EVT_ALARM;
                        end else begin
                            state_d = MON_SUSPECT;
                            ptype_s = EVT_ENTER_OUT;
                        end
                    end else begin
                        state_d = MON_ARMED;
                    end
                end
                MON_SUSPECT: begin
                    if (outside_s) begin
                        streak_d = streak_inc_s;
                        if (streak_inc_s == TRIP_W) begin
                            state_d = MON_ALARM;
                            alarm_d = 1'b1;
                            push_s  = 1'b1;
                            ptype_s = EVT_ALARM;
                        end else begin
                            state_d = MON_SUSPECT;
                        end
                    end else begin
                        state_d  = MON_ARMED;
                        streak_d = 8'd0;
                        push_s   = 1'b1;
                        ptype_s  = EVT_EXIT;
                    end
                end
                MON_ALARM: begin
                    if (outside_s) begin
                        streak_d = streak_inc_s;
                    end else begin
                        streak_d = 8'd0;
                        push_s   = 1'b1;
                        ptype_s  = EVT_EXIT;
                    end
                end
                default: begin
                    state_d  = MON_ARMED;
                    streak_d = 8'd0;
                    alarm_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign pop_s  = evt_valid && evt_ready;
    assign drop_s = push_s && full_s && !pop_s;

    // State, timestamp and drop bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MON_ARMED;
            streak_q   <= 8'd0;
            alarm_q    <= 1'b0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            alarm_q  <= alarm_d;
            ts_q     <= ts_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
            if (drop_s) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= sat_inc8(drop_cnt_q);
            end
        end
    end

    s247_evt_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({ptype_s, ts_q, presult_s}),
        .rdata_o (evt_data),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign evt_valid = !empty_s;
    assign alarm     = alarm_q;
    assign streak    = streak_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
